// File: rtl/mdsa_result_unloader.sv
// Streams a captured NxN sorted matrix out one element per transfer,
// in row-major (per-row direction aware) or column-major order.
module mdsa_result_unloader #(
    parameter int N  = 8,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap,
    input  logic [N*N*DW-1:0] data_in,
    input  logic [N-1:0]      dir,
    input  logic              col_major,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              overrun
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = (N > 1) ? $clog2(N * N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   o;
    logic [IW-1:0]   i;
    logic [IW-1:0]   o_nx;
    logic [IW-1:0]   i_nx;
    logic [DW-1:0]   mat [N*N];
    logic [N-1:0]    dir_h;
    logic            cm_h;
    logic            load;
    logic            ovr_set;
    logic            xfer;
    logic [IW-1:0]   r;
    logic [IW-1:0]   c;
    logic [AW-1:0]   idx;

    assign busy      = (state == STREAM);
    assign out_valid = busy;
    assign xfer      = busy & out_ready;
    assign out_last  = busy && (o == LAST) && (i == LAST);

    // Outer index walks rows (row-major) or columns (column-major).
    always_comb begin
        if (cm_h) begin
            r = i;
            c = o;
        end else begin
            r = o;
            c = dir_h[o] ? (LAST - i) : i;
        end
        idx      = AW'(r) * AW'(N) + AW'(c);
        out_data = busy ? mat[idx] : '0;
    end

    always_comb begin
        state_nx = state;
        o_nx     = o;
        i_nx     = i;
        load     = 1'b0;
        ovr_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cap) begin
                    load     = 1'b1;
                    o_nx     = '0;
                    i_nx     = '0;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                if (xfer && out_last) begin
                    o_nx = '0;
                    i_nx = '0;
                    if (cap) load = 1'b1;
                    else     state_nx = IDLE;
                end else begin
                    if (xfer) begin
                        if (i == LAST) begin
                            i_nx = '0;
                            o_nx = o + 1'b1;
                        end else begin
                            i_nx = i + 1'b1;
                        end
                    end
                    if (cap) ovr_set = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            o       <= '0;
            i       <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nx;
            o     <= o_nx;
            i     <= i_nx;
            if (ovr_set) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_h <= '0;
            cm_h  <= 1'b0;
            for (int k = 0; k < N * N; k++) mat[k] <= '0;
        end else if (load) begin
            dir_h <= dir;
            cm_h  <= col_major;
            for (int k = 0; k < N * N; k++) mat[k] <= data_in[k*DW +: DW];
        end
    end

endmodule

// File: tb/tb_mdsa_result_unloader.sv
// Directed bench for mdsa_result_unloader: ordering, direction,
// backpressure, capture overlap and asynchronous reset.
module tb_mdsa_result_unloader;

    localparam int N  = 8;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cap = 1'b0;
    logic [N*N*DW-1:0] data_in = '0;
    logic [N-1:0]      dir = '0;
    logic              col_major = 1'b0;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic              overrun;

    int nvec = 0;
    int nerr = 0;

    mdsa_result_unloader #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cap       (cap),
        .data_in   (data_in),
        .dir       (dir),
        .col_major (col_major),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N*N*DW-1:0] mk(input int base);
        logic [N*N*DW-1:0] m;
        m = '0;
        for (int k = 0; k < N * N; k++) m[k*DW +: DW] = DW'(base + k);
        return m;
    endfunction

    // Reference order: k-th streamed element of a matrix with (r,c)=base+r*N+c.
    function automatic int ev(input bit cm, input logic [N-1:0] d,
                              input int base, input int k);
        int r;
        int c;
        int j;
        if (cm) begin
            c = k / N;
            r = k % N;
        end else begin
            r = k / N;
            j = k % N;
            c = d[r] ? (N - 1 - j) : j;
        end
        return base + r * N + c;
    endfunction

    task automatic load(input int base, input logic [N-1:0] d, input bit cm);
        cap       = 1'b1;
        data_in   = mk(base);
        dir       = d;
        col_major = cm;
        @(posedge clk);
        #1;
        cap       = 1'b0;
        data_in   = mk(9000);
        dir       = ~d;
        col_major = ~cm;
    endtask

    task automatic recv(input bit cm, input logic [N-1:0] d, input int base,
                        input bit bp, input int stop, input int cap_at,
                        input int cap_base);
        int cnt = 0;
        int cyc = 0;
        while (cnt < stop && cyc < 4000) begin
            if (cnt == cap_at) begin
                cap       = 1'b1;
                data_in   = mk(cap_base);
                dir       = '0;
                col_major = 1'b0;
            end else begin
                cap       = 1'b0;
                data_in   = mk(9000);
                dir       = 8'h5A;
                col_major = 1'b1;
            end
            chk("valid", out_valid, 1);
            chk("data", out_data, ev(cm, d, base, cnt));
            chk("last", out_last, (cnt == N * N - 1) ? 1 : 0);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_ready) cnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        cap = 1'b0;
        if (cnt < stop) chk("timeout", cnt, stop);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_last"}, out_last, 0);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        idle_chk("rst");
        chk("rst_ovr", overrun, 0);
        chk("rst_data", out_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        idle_chk("post_rst");

        load(0, 8'h00, 1'b0);
        recv(1'b0, 8'h00, 0, 1'b0, 64, -1, 0);
        idle_chk("rowmaj");
        chk("rowmaj_ovr", overrun, 0);

        load(0, 8'h02, 1'b0);
        recv(1'b0, 8'h02, 0, 1'b0, 64, -1, 0);
        idle_chk("dir");

        load(0, 8'hA5, 1'b1);
        recv(1'b1, 8'hA5, 0, 1'b0, 64, -1, 0);
        idle_chk("colmaj");

        load(0, 8'h00, 1'b0);
        recv(1'b0, 8'h00, 0, 1'b1, 64, -1, 0);
        idle_chk("bp");

        load(0, 8'h00, 1'b0);
        recv(1'b0, 8'h00, 0, 1'b0, 64, 63, 100);
        chk("recap_valid", out_valid, 1);
        chk("recap_ovr", overrun, 0);
        recv(1'b0, 8'h00, 100, 1'b0, 64, -1, 0);
        idle_chk("recap");
        chk("recap_ovr2", overrun, 0);

        load(300, 8'h00, 1'b0);
        recv(1'b0, 8'h00, 300, 1'b0, 64, 20, 500);
        idle_chk("mid");
        chk("mid_ovr", overrun, 1);

        load(0, 8'h00, 1'b0);
        recv(1'b0, 8'h00, 0, 1'b0, 30, -1, 0);
        chk("pre_rst_data", out_data, 30);
        rst = 1'b0;
        #1;
        idle_chk("arst");
        chk("arst_ovr", overrun, 0);
        chk("arst_data", out_data, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("rel_valid", out_valid, 0);
        end
        load(200, 8'h00, 1'b0);
        recv(1'b0, 8'h00, 200, 1'b0, 64, -1, 0);
        idle_chk("restart");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
